// File: rtl/la_oai32_bist.sv
// la_oai32_bist: built-in self test that sweeps all 32 input vectors of an OAI32 gate and counts mismatches.
module la_oai32_bist #(
  parameter     PROP   = "DEFAULT",
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_z,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       b0,
  output logic       b1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [4:0] first_fail
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam int NVEC = 32;
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE - 1);
  localparam logic [4:0] LAST_VEC    = 5'(NVEC - 1);
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("la_oai32_bist (%s): SETTLE=%0d outside 1..15", PROP, SETTLE);
  end
  logic [1:0] state_q, state_d;
  logic [4:0] vec_q, vec_d, ff_q, ff_d;
  logic [3:0] settle_q, settle_d;
  logic [5:0] err_q, err_d;
  logic       pass_q, pass_d, expected, cmp;
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    expected = ~((vec_q[0] | vec_q[1] | vec_q[2]) & (vec_q[3] | vec_q[4]));
    // abort wins over a same-edge compare, so that compare is never counted
    cmp      = state_q == DRIVE && settle_q == LAST_SETTLE && !abort;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d  = DRIVE;
        vec_d    = '0;
        settle_d = '0;
        err_d    = '0;
        ff_d     = '0;
        pass_d   = 1'b0;
      end
    end else if (state_q == DRIVE) begin
      settle_d = settle_q + 4'd1;
      if (abort) begin
        state_d  = IDLE;
        vec_d    = '0;
        settle_d = '0;
        pass_d   = 1'b0;
      end else if (cmp) begin
        settle_d = '0;
        if (dut_z != expected) begin
          err_d = err_q + 6'd1;
          ff_d  = err_q == '0 ? vec_q : ff_q;
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
          vec_d   = '0;
          pass_d  = err_d == '0;
        end else begin
          vec_d = vec_q + 5'd1;
        end
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      pass_q   <= pass_d;
    end
  end
  assign {b1, b0, a2, a1, a0} = vec_q;
  assign busy       = state_q == DRIVE;
  assign done       = state_q == DONE;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
endmodule

// File: tb/tb_la_oai32_bist.sv
// tb_la_oai32_bist: directed table of GUT fault modes plus hand sequences for abort, reset and SETTLE=3.
module tb_la_oai32_bist;
  logic clk = 1'b0, nreset = 1'b0, start = 1'b0, abort = 1'b0;
  logic start3 = 1'b0, zero3 = 1'b0;
  logic a0, a1, a2, b0, b1, busy, done, pass, dut_z;
  logic [5:0] err_cnt;
  logic [4:0] first_fail;
  logic c0, c1, c2, d0, d1, busy3, done3, pass3, dut_z3;
  logic [5:0] err_cnt3;
  logic [4:0] first_fail3;
  logic [1:0] mode = 2'd0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // GUT stand-in: 0 ideal OAI32, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  logic ideal;
  assign ideal  = ~((a0 | a1 | a2) & (b0 | b1));
  assign dut_z  = mode == 2'd0 ? ideal : mode == 2'd1 ? 1'b0 : mode == 2'd2 ? 1'b1 : ~ideal;
  assign dut_z3 = ~((c0 | c1 | c2) & (d0 | d1));
  la_oai32_bist #(.SETTLE(1)) dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort), .dut_z(dut_z),
    .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail)
  );
  la_oai32_bist #(.SETTLE(3)) dut3 (
    .clk(clk), .nreset(nreset), .start(start3), .abort(zero3), .dut_z(dut_z3),
    .a0(c0), .a1(c1), .a2(c2), .b0(d0), .b1(d1), .busy(busy3), .done(done3),
    .pass(pass3), .err_cnt(err_cnt3), .first_fail(first_fail3)
  );
  typedef struct {
    logic [1:0] mode;
    int         err;
    int         ff;
    int         pass;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int gut_vec();
    return int'({b1, b0, a2, a1, a0});
  endfunction
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_vec(input int v);
    int n = 0;
    while (gut_vec() != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_vec_timeout", n, 0);
  endtask
  task automatic run_full(input string tag, input int exp_err, input int exp_ff, input int exp_pass);
    int cyc = 0;
    @(negedge clk);
    pulse_start();
    chk({tag, "_pass_cleared"}, int'(pass), 0);
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cyc, 32);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_pass_at_done"}, int'(pass), exp_pass);
    chk({tag, "_err_cnt"}, int'(err_cnt), exp_err);
    chk({tag, "_first_fail"}, int'(first_fail), exp_ff);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_idle_gut_zero"}, gut_vec(), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_pass_held"}, int'(pass), exp_pass);
    chk({tag, "_err_held"}, int'(err_cnt), exp_err);
  endtask
  initial begin
    tbl[0] = '{2'd0, 0, 0, 1};
    tbl[1] = '{2'd1, 11, 0, 0};
    tbl[2] = '{2'd2, 21, 9, 0};
    tbl[3] = '{2'd3, 32, 0, 0};
    tbl[4] = '{2'd0, 0, 0, 1};
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_outputs", int'({pass, err_cnt, first_fail}), 0);
    chk("reset_gut", gut_vec(), 0);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_full($sformatf("row%0d", i), tbl[i].err, tbl[i].ff, tbl[i].pass);
    end
    // start and abort together in IDLE must not launch a run
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);
    // abort at vector 8: vectors 0..7 mismatch under stuck-0, vector 8 compare dropped
    mode = 2'd1;
    pulse_start();
    wait_vec(8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort8_busy", int'(busy), 0);
    chk("abort8_done", int'(done), 0);
    chk("abort8_err", int'(err_cnt), 8);
    chk("abort8_ff", int'(first_fail), 0);
    chk("abort8_gut", gut_vec(), 0);
    @(negedge clk);
    chk("abort8_no_done", int'(done), 0);
    chk("abort8_pass", int'(pass), 0);
    // abort at vector 10 under stuck-0: vectors 0..9 give 9 mismatches
    pulse_start();
    wait_vec(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort10_err", int'(err_cnt), 9);
    chk("abort10_ff", int'(first_fail), 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_noeffect", int'(err_cnt), 9);
    // start during DRIVE is ignored: run still lasts 32 cycles
    mode = 2'd0;
    begin
      int cyc = 0;
      pulse_start();
      repeat (5) begin
        @(negedge clk);
        cyc++;
      end
      pulse_start();
      cyc++;
      while (busy && cyc < 200) begin
        cyc++;
        @(negedge clk);
      end
      chk("restart_ignored_cycles", cyc, 32);
      chk("restart_ignored_pass", int'(pass), 1);
    end
    @(negedge clk);
    // asynchronous reset at vector 20 with stuck-1 GUT (10 mismatches so far)
    mode = 2'd2;
    pulse_start();
    wait_vec(20);
    chk("prereset_err", int'(err_cnt), 10);
    #2 nreset = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_outputs", int'({done, pass, err_cnt, first_fail}), 0);
    chk("midreset_gut", gut_vec(), 0);
    @(negedge clk);
    nreset = 1'b1;
    mode = 2'd0;
    run_full("after_reset", 0, 0, 1);
    // SETTLE=3 instance: every vector held for 3 cycles, 96 busy cycles
    begin
      int cyc = 0, bad = 0;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      while (busy3 && cyc < 300) begin
        if (int'({d1, d0, c2, c1, c0}) != cyc / 3) bad++;
        cyc++;
        @(negedge clk);
      end
      chk("s3_busy_cycles", cyc, 96);
      chk("s3_vec_hold", bad, 0);
      chk("s3_done", int'(done3), 1);
      chk("s3_pass", int'(pass3), 1);
      chk("s3_err", int'(err_cnt3), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
